// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
//  - fetch_state_t : fetch controller states
//  - fetch_entry_t : one buffered fetch result {pc, instr, err}
//  - FETCH_RESET_PC / FETCH_NOP_INSTR : defaults for the fetch_stage parameters
//  - pc_next / is_misaligned : small address helpers
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FULL = 3'd3,
        S_ERR  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    // Sequential word address; wraps modulo 2^32 without any fault.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// IF stage of a 5-stage RV32I pipeline.
// Owns the PC, issues one word fetch at a time to instruction memory and keeps
// the most recent result in a one-entry buffer that feeds the IF/ID register.
// Ports:
//  clk, rst                 clock and synchronous active-high reset
//  stall                    IF/ID holding, buffer must not be consumed
//  redirect, redirect_pc    take a new PC (branch/jump/flush)
//  imem_req/addr/ready      request channel (req & ready = accepted)
//  imem_rvalid/rdata/err    response channel, one response per accepted request
//  fetch_valid              buffer holds a real instruction (or a fault entry)
//  pc_out/instr_out         buffered PC and instruction (NOP when empty/fault)
//  pcPlus4_out              pc_out + 4
//  err_out                  fetch fault: bus error or misaligned redirect target
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        fetch_valid,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [31:0] pcPlus4_out,
    output logic        err_out
);

    fetch_state_t state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  req_pc_r, req_pc_s;
    logic         drop_r, drop_s;
    logic         err_pend_r, err_pend_s;
    logic         buf_valid_r, buf_valid_s;
    fetch_entry_t buf_r, buf_s;
    logic [31:0]  buf_pc4_r, buf_pc4_s;

    logic         consume_s;
    logic         handshake_s;
    logic         outstanding_s;
    logic         misaligned_s;

    // Request side: a request is only raised when the buffer will be free by the
    // time the response returns, which gives back-to-back fetches every 2 cycles.
    always_comb begin
        consume_s     = buf_valid_r & ~stall & ~redirect;
        imem_req      = (state_r == S_REQ) & (~buf_valid_r | consume_s);
        imem_addr     = pc_r;
        handshake_s   = imem_req & imem_ready;
        misaligned_s  = is_misaligned(redirect_pc);
        // A response is still owed to us after this edge.
        outstanding_s = ((state_r == S_WAIT) & ~imem_rvalid) | handshake_s;
    end

    // Next-state logic for the controller, PC, drop flag and output buffer.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        req_pc_s    = req_pc_r;
        drop_s      = drop_r;
        err_pend_s  = err_pend_r;
        buf_valid_s = buf_valid_r;
        buf_s       = buf_r;
        buf_pc4_s   = buf_pc4_r;

        if (redirect) begin
            pc_s       = redirect_pc;
            drop_s     = outstanding_s;
            // Remembered so that draining a stale response ends in S_ERR.
            err_pend_s = misaligned_s;
            if (misaligned_s) begin
                buf_valid_s = 1'b1;
                buf_s.pc    = redirect_pc;
                buf_s.instr = NOP_INSTR;
                buf_s.err   = 1'b1;
                buf_pc4_s   = pc_next(redirect_pc);
            end else begin
                buf_valid_s = 1'b0;
                buf_s.instr = NOP_INSTR;
                buf_s.err   = 1'b0;
            end
            if (outstanding_s) begin
                state_s = S_WAIT;
            end else if (misaligned_s) begin
                state_s = S_ERR;
            end else begin
                state_s = S_REQ;
            end
        end else begin
            if (consume_s) begin
                buf_valid_s = 1'b0;
                buf_s.instr = NOP_INSTR;
                buf_s.err   = 1'b0;
            end else begin
                buf_valid_s = buf_valid_r;
            end

            case (state_r)
                S_IDLE: begin
                    state_s = S_REQ;
                end
                S_REQ: begin
                    if (handshake_s) begin
                        req_pc_s = pc_r;
                        pc_s     = pc_next(pc_r);
                        state_s  = S_WAIT;
                    end else begin
                        state_s  = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && drop_r) begin
                        drop_s  = 1'b0;
                        state_s = err_pend_r ? S_ERR : S_REQ;
                    end else if (imem_rvalid) begin
                        buf_valid_s = 1'b1;
                        buf_s.pc    = req_pc_r;
                        buf_s.instr = imem_err ? NOP_INSTR : imem_rdata;
                        buf_s.err   = imem_err;
                        buf_pc4_s   = pc_next(req_pc_r);
                        if (imem_err) begin
                            state_s = S_ERR;
                        end else if (!buf_valid_r || consume_s) begin
                            state_s = S_REQ;
                        end else begin
                            state_s = S_FULL;
                        end
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_FULL: begin
                    state_s = consume_s ? S_REQ : S_FULL;
                end
                S_ERR: begin
                    state_s = S_ERR;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            req_pc_r     <= RESET_PC;
            drop_r       <= 1'b0;
            err_pend_r   <= 1'b0;
            buf_valid_r  <= 1'b0;
            buf_r.pc     <= 32'h0000_0000;
            buf_r.instr  <= NOP_INSTR;
            buf_r.err    <= 1'b0;
            buf_pc4_r    <= 32'h0000_0004;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            req_pc_r     <= req_pc_s;
            drop_r       <= drop_s;
            err_pend_r   <= err_pend_s;
            buf_valid_r  <= buf_valid_s;
            buf_r        <= buf_s;
            buf_pc4_r    <= buf_pc4_s;
        end
    end

    // Outputs come straight from the buffer registers.
    always_comb begin
        fetch_valid = buf_valid_r;
        pc_out      = buf_r.pc;
        instr_out   = buf_r.instr;
        err_out     = buf_r.err;
        pcPlus4_out = buf_pc4_r;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model and a
// small memory responder whose response latency can be varied per scenario.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst, stall, redirect, imem_ready, imem_rvalid, imem_err;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, fetch_valid, err_out;
    logic [31:0] imem_addr, pc_out, instr_out, pcPlus4_out;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .fetch_valid(fetch_valid), .pc_out(pc_out), .instr_out(instr_out),
        .pcPlus4_out(pcPlus4_out), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // stimulus requested for the next cycle
    logic        s_rst = 1'b1, s_stall = 1'b0, s_redirect = 1'b0, s_ready = 1'b1;
    logic [31:0] s_rpc = 32'h0;

    // memory responder
    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t        rsp_q[$];
    logic [31:0] addr_log[$];
    int          rsp_delay = 1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    // reference model
    logic        m_known = 1'b0, m_started, m_out, m_stale, m_halt, m_bv, m_berr;
    logic [31:0] m_pc, m_reqpc, m_bpc, m_binstr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[15:0], 16'h0000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        logic consume, ereq;
        if (!m_known) return;
        consume = m_bv && !stall && !redirect;
        ereq    = m_started && !m_halt && !m_out && (!m_bv || consume);
        chk("req", {31'd0, imem_req}, {31'd0, ereq});
        if (ereq) chk("addr", imem_addr, m_pc);
        chk("valid", {31'd0, fetch_valid}, {31'd0, m_bv});
        chk("instr", instr_out, m_bv ? m_binstr : NOP);
        chk("err", {31'd0, err_out}, {31'd0, m_bv && m_berr});
        if (m_bv) begin
            chk("pc", pc_out, m_bpc);
            chk("pc4", pcPlus4_out, m_bpc + 32'd4);
        end
    endtask

    task automatic model_advance();
        logic consume, ereq, hs, rsp;
        if (rst) begin
            m_known = 1'b1; m_started = 1'b0; m_pc = 32'h0; m_reqpc = 32'h0;
            m_out = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
            m_bv = 1'b0; m_bpc = 32'h0; m_binstr = NOP; m_berr = 1'b0;
            return;
        end
        if (!m_known) return;
        consume = m_bv && !stall && !redirect;
        ereq    = m_started && !m_halt && !m_out && (!m_bv || consume);
        hs      = ereq && imem_ready;
        rsp     = m_out && imem_rvalid;
        m_started = 1'b1;
        if (redirect) begin
            m_out   = (m_out && !imem_rvalid) || hs;
            m_stale = m_out;
            m_pc    = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                m_halt = 1'b1; m_bv = 1'b1; m_bpc = redirect_pc; m_binstr = NOP; m_berr = 1'b1;
            end else begin
                m_halt = 1'b0; m_bv = 1'b0;
            end
        end else begin
            if (consume) m_bv = 1'b0;
            if (rsp) begin
                m_out = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_bv = 1'b1; m_bpc = m_reqpc; m_berr = imem_err;
                    m_binstr = imem_err ? NOP : imem_rdata;
                    if (imem_err) m_halt = 1'b1;
                end
            end
            if (hs) begin
                m_out = 1'b1; m_stale = 1'b0; m_reqpc = m_pc; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock cycle: apply inputs at the falling edge, check, then advance model and memory.
    task automatic tick();
        rsp_t r;
        @(negedge clk);
        rst = s_rst; stall = s_stall; redirect = s_redirect; redirect_pc = s_rpc; imem_ready = s_ready;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(r.addr);
            imem_err    = err_en && (r.addr == err_addr);
        end
        #2;
        compare_outputs();
        if (imem_req === 1'b1 && imem_ready) begin
            r.addr = imem_addr; r.due = cyc + rsp_delay;
            rsp_q.push_back(r);
            addr_log.push_back(imem_addr);
        end
        model_advance();
        cyc++;
    endtask

    task automatic wait_valid(input string name, input int max, output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < max && !seen; i++) begin
            tick(); n++;
            if (fetch_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: fetch_valid not seen within %0d cycles", name, max);
        end
    endtask

    task automatic wait_req(input string name, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (imem_req === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: imem_req not seen within %0d cycles", name, max);
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        s_redirect = 1'b1; s_rpc = target;
        tick();
        s_redirect = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;

        // reset values
        tick(); tick();
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'h0000_0013);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pcPlus4_out, 32'h4);
        chk("rst_err", {31'd0, err_out}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        s_rst = 1'b0;
        addr_log.delete();

        // first fetch and 2-cycle throughput
        wait_valid("first", 10, n);
        chk("first_lat", n, 32'd4);
        chk("first_pc", pc_out, 32'h0);
        chk("first_instr", instr_out, 32'h0050_0093);
        chk("first_pc4", pcPlus4_out, 32'h4);
        wait_valid("second", 10, n);
        chk("throughput", n, 32'd2);
        chk("second_pc", pc_out, 32'h4);

        // stall with a full buffer
        s_stall = 1'b1;
        wait_valid("stall_fill", 10, n);
        chk("stall_pc0", pc_out, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_out, 32'h8);
            chk("stall_instr", instr_out, 32'h0058_0093);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        s_stall = 1'b0;
        tick();
        chk("release_addr", imem_addr, 32'hC);
        wait_valid("release", 10, n);
        chk("release_pc", pc_out, 32'hC);
        chk("log0", addr_log[0], 32'h0);
        chk("log1", addr_log[1], 32'h4);
        chk("log2", addr_log[2], 32'h8);
        chk("log3", addr_log[3], 32'hC);

        // redirect while waiting: the returning response is dropped
        rsp_delay = 3;
        wait_req("rq_wait", 10);
        do_redirect(32'h0000_0100);
        wait_req("rq_100", 10);
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid("redir", 15, n);
        chk("redir_pc", pc_out, 32'h100);

        // redirect in the same cycle as rvalid
        rsp_delay = 1;
        wait_req("rq_same", 10);
        do_redirect(32'h0000_0180);
        tick();
        chk("same_novalid", {31'd0, fetch_valid}, 32'd0);
        chk("same_addr", imem_addr, 32'h180);
        wait_valid("same", 10, n);
        chk("same_pc", pc_out, 32'h180);

        // bus error at address 8
        err_en = 1'b1; err_addr = 32'h8;
        do_redirect(32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (err_out === 1'b1) seen = 1'b1;
        end
        chk("buserr_seen", {31'd0, seen}, 32'd1);
        chk("buserr_pc", pc_out, 32'h8);
        chk("buserr_instr", instr_out, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("buserr_noreq", {31'd0, imem_req}, 32'd0);
        end
        err_en = 1'b0;

        // misaligned redirect, then recovery
        do_redirect(32'h0000_0102);
        tick();
        chk("mis_valid", {31'd0, fetch_valid}, 32'd1);
        chk("mis_err", {31'd0, err_out}, 32'd1);
        chk("mis_pc", pc_out, 32'h102);
        chk("mis_instr", instr_out, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mis_noreq", {31'd0, imem_req}, 32'd0);
        end
        do_redirect(32'h0000_0200);
        wait_req("rq_200", 10);
        chk("resume_addr", imem_addr, 32'h200);
        wait_valid("resume", 10, n);
        chk("resume_pc", pc_out, 32'h200);
        chk("resume_err", {31'd0, err_out}, 32'd0);

        // misaligned redirect with a response still in flight
        rsp_delay = 3;
        wait_req("rq_mis2", 10);
        do_redirect(32'h0000_0306);
        tick();
        chk("mis2_err", {31'd0, err_out}, 32'd1);
        chk("mis2_pc", pc_out, 32'h306);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mis2_noreq", {31'd0, imem_req}, 32'd0);
        end

        // PC wrap-around
        rsp_delay = 1;
        do_redirect(32'hFFFF_FFFC);
        wait_req("rq_wrap", 10);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap", 10, n);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc4", pcPlus4_out, 32'h0);
        chk("wrap_err", {31'd0, err_out}, 32'd0);
        chk("wrap_next", addr_log[addr_log.size() - 1], 32'h0);

        // reset in the middle of a transaction; the late response is ignored
        rsp_delay = 3;
        wait_req("rq_rst", 10);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        wait_valid("after_rst", 15, n);
        chk("rst2_pc", pc_out, 32'h0);
        chk("rst2_instr", instr_out, 32'h0050_0093);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
